// File: rtl/dm_desc_arb_pkg.sv
// Shared definitions for the descriptor arbiter: descriptor width and arbiter state.
package dm_desc_arb_pkg;

  localparam int unsigned DM_DESC_WIDTH = 174;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest request index after the one-hot pointer wins.
module rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic         found,
  output logic [1:0]   idx
);

  always_comb begin
    int last_idx;
    int k;
    last_idx = 0;
    k        = 0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (ptr[i]) last_idx = i;
    end
    // Walk offsets from farthest to nearest so the nearest requester overwrites last.
    for (int off = int'(N); off >= 1; off--) begin
      k = (last_idx + off) % int'(N);
      if (req[k]) begin
        found = 1'b1;
        idx   = 2'(k);
      end
    end
  end

endmodule

// File: rtl/dm_desc_arb.sv
// Locking round-robin arbiter merging descriptor requesters onto one data-mover port.
module dm_desc_arb
  import dm_desc_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*DM_DESC_WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]              req_last,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_en,
  output logic                         rddm_desc_valid,
  output logic [DM_DESC_WIDTH-1:0]     rddm_desc_data,
  input  logic                         rddm_desc_ready,
  output logic [1:0]                   grant_id,
  output logic                         busy,
  output logic [NREQ*CNT_WIDTH-1:0]    desc_cnt
);

  arb_state_e                 state_q;
  logic [1:0]                 grant_q;
  logic [1:0]                 last_q;
  logic                       out_valid_q;
  logic [DM_DESC_WIDTH-1:0]   out_data_q;
  logic [NREQ*CNT_WIDTH-1:0]  cnt_q;

  logic [NREQ-1:0]            ptr;
  logic [NREQ-1:0]            eligible;
  logic [NREQ-1:0]            acc;
  logic                       pick_found;
  logic [1:0]                 pick_idx;
  logic                       accept;
  logic                       acc_last;
  logic [DM_DESC_WIDTH-1:0]   sel_data;

  assign ptr      = NREQ'(1) << last_q;
  assign eligible = req_valid & req_en;

  rr_pick #(
    .N (NREQ)
  ) u_rr_pick (
    .req   (eligible),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    sel_data  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_q == 2'(i)) begin
        sel_data = req_data[i*DM_DESC_WIDTH +: DM_DESC_WIDTH];
        if (state_q == StLocked) req_ready[i] = !out_valid_q || rddm_desc_ready;
      end
    end
  end

  assign acc      = req_valid & req_ready;
  assign accept   = |acc;
  assign acc_last = |(acc & req_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= 2'(NREQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      // A fresh accept reloads the register even while it drains, so no bubble.
      if (accept) begin
        out_data_q  <= sel_data;
        out_valid_q <= 1'b1;
      end else if (rddm_desc_ready) begin
        out_valid_q <= 1'b0;
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (acc[i]) begin
          cnt_q[i*CNT_WIDTH +: CNT_WIDTH] <= cnt_q[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end
      end
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            state_q <= StLocked;
          end
        end
        StLocked: begin
          if (acc_last) begin
            last_q  <= grant_q;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign busy            = (state_q == StLocked);
  assign grant_id        = grant_q;
  assign rddm_desc_valid = out_valid_q;
  assign rddm_desc_data  = out_data_q;
  assign desc_cnt        = cnt_q;

endmodule

// File: tb/tb_dm_desc_arb.sv
// Directed bench for dm_desc_arb: cycle table plus round-robin and mid-burst reset sequences.
module tb_dm_desc_arb;
  import dm_desc_arb_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned CW   = 16;
  localparam int unsigned W    = DM_DESC_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_last, req_ready, req_en;
  logic [NREQ*W-1:0]    req_data;
  logic                 rddm_desc_valid, rddm_desc_ready;
  logic [W-1:0]         rddm_desc_data;
  logic [1:0]           grant_id;
  logic                 busy;
  logic [NREQ*CW-1:0]   desc_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_desc_arb #(
    .NREQ      (NREQ),
    .CNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .req_en          (req_en),
    .rddm_desc_valid (rddm_desc_valid),
    .rddm_desc_data  (rddm_desc_data),
    .rddm_desc_ready (rddm_desc_ready),
    .grant_id        (grant_id),
    .busy            (busy),
    .desc_cnt        (desc_cnt)
  );

  typedef struct {
    logic [1:0] v, last, en;
    logic       dr;
    logic [7:0] t0, t1;
    logic [1:0] e_rdy;
    logic       e_val;
    logic [7:0] e_tag;
    logic       e_busy;
    logic [1:0] e_gid;
    logic [15:0] e_c0, e_c1;
  } vec_t;

  vec_t vecs[34];

  function automatic logic [W-1:0] mk(input logic [7:0] t);
    return {{21{t}}, 6'h2A};
  endfunction

  function automatic vec_t mv(input logic [1:0] v, input logic [1:0] last, input logic [1:0] en,
                              input logic dr, input logic [7:0] t0, input logic [7:0] t1,
                              input logic [1:0] erdy, input logic evl, input logic [7:0] etag,
                              input logic ebusy, input logic [1:0] egid,
                              input logic [15:0] ec0, input logic [15:0] ec1);
    vec_t r;
    r.v = v; r.last = last; r.en = en; r.dr = dr; r.t0 = t0; r.t1 = t1;
    r.e_rdy = erdy; r.e_val = evl; r.e_tag = etag; r.e_busy = ebusy; r.e_gid = egid;
    r.e_c0 = ec0; r.e_c1 = ec1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  initial begin
    bit seen;
    int got;
    int idx;

    // Single burst, RR start, 2-beat burst lock, backpressure, req_en gating, lock hold
    vecs[0]  = mv(2'b00, 2'b00, 2'b11, 1, 8'h00, 8'h00, 2'b00, 0, 8'h00, 0, 0, 0, 0);
    vecs[1]  = mv(2'b01, 2'b01, 2'b11, 1, 8'h0A, 8'h00, 2'b00, 0, 8'h00, 0, 0, 0, 0);
    vecs[2]  = mv(2'b01, 2'b01, 2'b11, 1, 8'h0A, 8'h00, 2'b01, 0, 8'h00, 1, 0, 0, 0);
    vecs[3]  = mv(2'b00, 2'b00, 2'b11, 1, 8'h00, 8'h00, 2'b00, 1, 8'h0A, 0, 0, 1, 0);
    vecs[4]  = mv(2'b00, 2'b00, 2'b11, 1, 8'h00, 8'h00, 2'b00, 0, 8'h00, 0, 0, 1, 0);
    vecs[5]  = mv(2'b11, 2'b00, 2'b11, 1, 8'hB0, 8'hB1, 2'b00, 0, 8'h00, 0, 0, 1, 0);
    vecs[6]  = mv(2'b11, 2'b00, 2'b11, 1, 8'hB0, 8'hB1, 2'b10, 0, 8'h00, 1, 1, 1, 0);
    vecs[7]  = mv(2'b11, 2'b10, 2'b11, 1, 8'hB0, 8'hB2, 2'b10, 1, 8'hB1, 1, 1, 1, 1);
    vecs[8]  = mv(2'b01, 2'b01, 2'b11, 1, 8'hB0, 8'h00, 2'b00, 1, 8'hB2, 0, 0, 1, 2);
    vecs[9]  = mv(2'b01, 2'b01, 2'b11, 1, 8'hB0, 8'h00, 2'b01, 0, 8'h00, 1, 0, 1, 2);
    vecs[10] = mv(2'b00, 2'b00, 2'b11, 1, 8'h00, 8'h00, 2'b00, 1, 8'hB0, 0, 0, 2, 2);
    vecs[11] = mv(2'b10, 2'b00, 2'b11, 0, 8'h00, 8'hC1, 2'b00, 0, 8'h00, 0, 0, 2, 2);
    vecs[12] = mv(2'b10, 2'b00, 2'b11, 0, 8'h00, 8'hC1, 2'b10, 0, 8'h00, 1, 1, 2, 2);
    for (int i = 13; i <= 17; i++)
      vecs[i] = mv(2'b10, 2'b00, 2'b11, 0, 8'h00, 8'hC2, 2'b00, 1, 8'hC1, 1, 1, 2, 3);
    vecs[18] = mv(2'b10, 2'b00, 2'b11, 1, 8'h00, 8'hC2, 2'b10, 1, 8'hC1, 1, 1, 2, 3);
    vecs[19] = mv(2'b10, 2'b10, 2'b11, 1, 8'h00, 8'hC3, 2'b10, 1, 8'hC2, 1, 1, 2, 4);
    vecs[20] = mv(2'b00, 2'b00, 2'b11, 1, 8'h00, 8'h00, 2'b00, 1, 8'hC3, 0, 0, 2, 5);
    vecs[21] = mv(2'b00, 2'b00, 2'b11, 1, 8'h00, 8'h00, 2'b00, 0, 8'h00, 0, 0, 2, 5);
    vecs[22] = mv(2'b01, 2'b01, 2'b10, 1, 8'hD0, 8'h00, 2'b00, 0, 8'h00, 0, 0, 2, 5);
    vecs[23] = mv(2'b01, 2'b01, 2'b10, 1, 8'hD0, 8'h00, 2'b00, 0, 8'h00, 0, 0, 2, 5);
    vecs[24] = mv(2'b01, 2'b01, 2'b11, 1, 8'hD0, 8'h00, 2'b00, 0, 8'h00, 0, 0, 2, 5);
    vecs[25] = mv(2'b01, 2'b01, 2'b11, 1, 8'hD0, 8'h00, 2'b01, 0, 8'h00, 1, 0, 2, 5);
    vecs[26] = mv(2'b01, 2'b00, 2'b11, 1, 8'hE1, 8'h00, 2'b00, 1, 8'hD0, 0, 0, 3, 5);
    vecs[27] = mv(2'b01, 2'b00, 2'b11, 1, 8'hE1, 8'h00, 2'b01, 0, 8'h00, 1, 0, 3, 5);
    vecs[28] = mv(2'b10, 2'b00, 2'b10, 1, 8'h00, 8'hEE, 2'b01, 1, 8'hE1, 1, 0, 4, 5);
    vecs[29] = mv(2'b10, 2'b00, 2'b10, 1, 8'h00, 8'hEE, 2'b01, 0, 8'h00, 1, 0, 4, 5);
    vecs[30] = mv(2'b11, 2'b01, 2'b10, 1, 8'hE2, 8'hEE, 2'b01, 0, 8'h00, 1, 0, 4, 5);
    vecs[31] = mv(2'b10, 2'b10, 2'b11, 1, 8'h00, 8'hEE, 2'b00, 1, 8'hE2, 0, 0, 5, 5);
    vecs[32] = mv(2'b10, 2'b10, 2'b11, 1, 8'h00, 8'hEE, 2'b10, 0, 8'h00, 1, 1, 5, 5);
    vecs[33] = mv(2'b00, 2'b00, 2'b11, 1, 8'h00, 8'h00, 2'b00, 1, 8'hEE, 0, 0, 5, 6);

    rst = 1'b1;
    req_valid = '0; req_last = '0; req_en = '0; req_data = '0; rddm_desc_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      req_valid = vecs[i].v; req_last = vecs[i].last; req_en = vecs[i].en;
      rddm_desc_ready = vecs[i].dr;
      req_data = {mk(vecs[i].t1), mk(vecs[i].t0)};
      #1;
      chk($sformatf("v%0d req_ready", i), 256'(req_ready), 256'(vecs[i].e_rdy));
      chk($sformatf("v%0d valid", i), 256'(rddm_desc_valid), 256'(vecs[i].e_val));
      chk($sformatf("v%0d busy", i), 256'(busy), 256'(vecs[i].e_busy));
      chk($sformatf("v%0d cnt0", i), 256'(desc_cnt[CW-1:0]), 256'(vecs[i].e_c0));
      chk($sformatf("v%0d cnt1", i), 256'(desc_cnt[2*CW-1:CW]), 256'(vecs[i].e_c1));
      if (vecs[i].e_val)
        chk($sformatf("v%0d data", i), 256'(rddm_desc_data), 256'(mk(vecs[i].e_tag)));
      if (vecs[i].e_busy)
        chk($sformatf("v%0d grant_id", i), 256'(grant_id), 256'(vecs[i].e_gid));
    end

    // Both requesters always valid with single-beat bursts: strict 0,1,0,1 order
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b11; req_last = 2'b11; req_en = 2'b11; rddm_desc_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      #1;
      if (|(req_ready & req_valid)) begin
        idx = req_ready[1] ? 1 : 0;
        chk($sformatf("rr order %0d", got), 256'(idx), 256'(got % 2));
        got++;
      end
      @(negedge clk);
    end
    if (got < 8) chk("rr timeout accepts", 256'(got), 256'(8));
    req_valid = '0;
    #1;
    chk("rr cnt0", 256'(desc_cnt[CW-1:0]), 256'(4));
    chk("rr cnt1", 256'(desc_cnt[2*CW-1:CW]), 256'(4));

    // Reset in the middle of a locked burst with an undelivered descriptor
    @(negedge clk);
    req_valid = 2'b01; req_last = 2'b00; rddm_desc_ready = 1'b0; req_data = {mk(8'h11), mk(8'h55)};
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (busy) seen = 1'b1;
    end
    chk("mid busy before reset", 256'(busy), 256'(1));
    @(negedge clk);
    #1;
    chk("mid valid before reset", 256'(rddm_desc_valid), 256'(1));
    rst = 1'b1; rddm_desc_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    #1;
    chk("post-rst valid", 256'(rddm_desc_valid), 256'(0));
    chk("post-rst busy", 256'(busy), 256'(0));
    chk("post-rst ready", 256'(req_ready), 256'(0));
    chk("post-rst counts", 256'(desc_cnt), 256'(0));
    req_valid = 2'b11; req_last = 2'b11;
    @(negedge clk);
    #1;
    chk("post-rst grant busy", 256'(busy), 256'(1));
    chk("post-rst grant id", 256'(grant_id), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_desc_arb.md
DM_DESC_ARB -- requirements
Module: dm_desc_arb

Interface
REQ-001 Parameter NREQ, default 2, number of descriptor requesters (2..4).
REQ-002 Parameter CNT_WIDTH, default 32, width of per-requester accepted-descriptor counters.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  NREQ  descriptor offered by requester i.
REQ-006 Port req_data  input  NREQ*174  descriptor from requester i; slice i occupies bits [174*i+173:174*i].
REQ-007 Port req_last  input  NREQ  marks the final descriptor of requester i's burst, releasing the lock.
REQ-008 Port req_ready  output  NREQ  requester i's descriptor is accepted this cycle.
REQ-009 Port req_en  input  NREQ  requester i is eligible for new grants.
REQ-010 Port rddm_desc_valid  output  1  descriptor toward the read data-mover.
REQ-011 Port rddm_desc_data  output  174  descriptor payload.
REQ-012 Port rddm_desc_ready  input  1  data-mover accepts the descriptor.
REQ-013 Port grant_id  output  2  requester currently owning the port; valid when busy=1.
REQ-014 Port busy  output  1  a burst is locked to a requester.
REQ-015 Port desc_cnt  output  NREQ*CNT_WIDTH  accepted descriptors per requester; wraps on overflow.

Function
REQ-016 FSM states: IDLE and LOCKED.
REQ-017 IDLE: if any requester has req_valid=1 and req_en=1, grant the winner by round-robin, starting search at (last_grant+1) mod NREQ; go to LOCKED; set grant_id and busy=1 at the next edge.
REQ-018 No descriptor is accepted in the cycle the arbitration decision is made; minimum 1 cycle from IDLE req_valid to req_ready.
REQ-019 LOCKED: req_ready[g] = (!rddm_desc_valid or rddm_desc_ready) for granted g; all other req_ready = 0.
REQ-020 Accept (req_valid[g] and req_ready[g]): load req_data[g] into the output register; rddm_desc_valid=1 next cycle (1-cycle latency); desc_cnt[g] increments by 1.
REQ-021 rddm_desc_valid is cleared when rddm_desc_ready=1 and no accept occurs in the same cycle; data holds stable while valid=1 and ready=0.
REQ-022 Simultaneous output drain and new accept: the output register reloads, valid stays 1, with no bubble (full throughput).
REQ-023 Accept with req_last[g]=1: record last_grant=g, return to IDLE next cycle, busy=0.
REQ-024 Lock is never broken by req_valid deassertion, req_en deassertion, or other requesters' activity; DESC_LOW/DESC_HIGH pairs stay back-to-back.
REQ-025 req_en only gates new grants in IDLE.
REQ-026 Descriptors are passed through unmodified; all 174 bits are preserved.
REQ-027 Output register remains valid across the LOCKED-to-IDLE transition until drained.
REQ-028 Single requester repeatedly requesting: it is re-granted after each burst; 1 IDLE cycle between bursts.

Reset
REQ-029 On rst: state=IDLE, rddm_desc_valid=0, req_ready=0, busy=0, grant_id=0, last_grant=NREQ-1, desc_cnt=0.
REQ-030 Reset mid-burst drops the lock and any undelivered output descriptor; reset takes priority over every handshake in that cycle.

Structure
REQ-031 The 174-bit descriptor width (DM_DESC_WIDTH) and the arbiter state enum belong in the shared struct/package include.
REQ-032 Round-robin winner selection is one sub-module, rr_pick (combinational, NREQ-wide request and pointer).

Verification
REQ-033 Reset, then req0 offers {0xA,last=1} -> rddm_desc_valid with data 0xA two cycles after req_valid; desc_cnt[0]=1.
REQ-034 req0 and req1 valid simultaneously from reset, single-descriptor bursts -> grant order 0,1,0,1; counts equal after 8 descriptors.
REQ-035 req1 sends 2-descriptor burst (last on 2nd) while req0 is valid -> both req1 descriptors emitted consecutively before any req0 descriptor.
REQ-036 rddm_desc_ready held 0 for 5 cycles with valid=1 -> data stable, req_ready=0; on release, next descriptor follows with no bubble.
REQ-037 req_en[0]=0 with req0 valid -> req0 never granted; reasserting req_en[0] -> grant within 2 cycles.
REQ-038 rst asserted mid-burst -> next cycle valid=0, busy=0, counts=0; a fresh request then grants from requester 0.
